sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo.sv | 74 +++++++
 tb/tb_sync_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO constants: default geometry and the pointer/count width rules
// used by both the control logic and the storage block.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    // count must be able to hold DEPTH itself, hence depth+1
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port, no reset.
// rdata holds its value in cycles without a read.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = ptr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: pointers, occupancy count, registered flags and
// overflow/underflow pulses around a fifo_mem storage block.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_bits(DEPTH),
    localparam int CW   = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             unf
);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] rd_data;
    logic             wr_acc, rd_acc;
    logic             dout_clr;

    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign count_nxt = count + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            dout_clr <= 1'b1;
        end else begin
            // power-of-two depth: pointers wrap naturally at DEPTH-1 -> 0
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            if (rd_acc) dout_clr <= 1'b0;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            ovf   <= wr_en && full;
            unf   <= rd_en && empty;
        end
    end

    // The storage read register has no reset, so dout reads as zero until
    // the first read after reset refreshes it.
    assign dout = dout_clr ? '0 : rd_data;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_acc && !rst),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts the
// outputs of every cycle; a negedge monitor pops and compares them.
module tb_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk, rst, wr_en, rd_en;
    logic [W-1:0]  din, dout;
    logic          full, empty, ovf, unf;
    logic [CW-1:0] count;

    sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dout;
        int           count;
        logic         full, empty, ovf, unf;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    int           checks, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: FIFO as a data queue, acceptance decided from its size.
    function automatic exp_t model_step(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
        exp_t e;
        bit   was_full, was_empty, w_ok, r_ok;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (r) begin
            mq.delete();
            m_dout = '0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            w_ok = w && !was_full;
            r_ok = rd && !was_empty;
            if (r_ok) m_dout = mq.pop_front();
            if (w_ok) mq.push_back(d);
            e.ovf = w && !w_ok;
            e.unf = rd && !r_ok;
        end
        e.dout  = m_dout;
        e.count = mq.size();
        e.full  = (mq.size() == D);
        e.empty = (mq.size() == 0);
        return e;
    endfunction

    task automatic cyc(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
        exp_t e;
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        e = model_step(r, w, rd, d);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("dout",  32'(dout),  32'(mon_e.dout));
            chk("count", 32'(count), 32'(mon_e.count));
            chk("full",  32'(full),  32'(mon_e.full));
            chk("empty", 32'(empty), 32'(mon_e.empty));
            chk("ovf",   32'(ovf),   32'(mon_e.ovf));
            chk("unf",   32'(unf),   32'(mon_e.unf));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_dout = '0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // reset then idle
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // fill, overflow, drain, underflow
        for (int i = 1; i <= D; i++) cyc(0, 1, 0, 8'(i));
        cyc(0, 1, 0, 8'hAA);
        cyc(0, 0, 0, 8'h00);
        for (int i = 0; i < D; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // simultaneous read/write while full
        for (int i = 0; i < D; i++) cyc(0, 1, 0, 8'(8'h40 + i));
        cyc(0, 1, 1, 8'h77);
        for (int i = 0; i < D; i++) cyc(0, 0, 1, 8'h00);

        // simultaneous read/write while empty, then read the word back
        cyc(0, 1, 1, 8'h5C);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // random interleaved traffic across several pointer wraps
        for (int i = 0; i < 200; i++)
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

        // mid-operation reset with five words stored
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h90 + i));
        cyc(1, 1, 1, 8'h99);
        cyc(0, 1, 0, 8'h33);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
